pinwheel_console: RTL and testbench
===================================

# pinwheel_console

Memory-mapped debug console and status peripheral on the pinwheel data bus, decoded in the 0xFxxxxxxx debug-register region. Downstream of `pinwheel_core`: it consumes the core's `sig_bus_*` stage-B outputs and returns read data one cycle later, in time for the core's stage-C regfile write. Stored bytes go into a TX FIFO and drain over a valid/ready byte stream to the host or simulator console. Also provides a free-running cycle counter and a scratch register.

## Interface
Parameters:
- DEPTH, 16, TX FIFO entries; must be a power of two, at least 2.
- BASE, 32'hF0000000, base address of the 16-byte register window.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- tock_reset_in  in  1  synchronous, active-high reset.
- tock_bus_addr  in  32  byte address from the core (`sig_bus_addr`).
- tock_bus_rden  in  1  load strobe.
- tock_bus_wdata  in  32  store data, unshifted.
- tock_bus_wmask  in  4  store byte mask, already shifted by address.
- tock_bus_wren  in  1  store strobe.
- sig_bus_rdata  out  32  registered read data, valid the cycle after `rden`.
- sig_tx_data  out  8  head-of-FIFO byte.
- sig_tx_valid  out  1  FIFO non-empty.
- tock_tx_ready  in  1  consumer accepts the byte this cycle.
- sig_irq_overflow  out  1  sticky overflow flag.

## Operation
- Select: `cs = (addr & ~32'hF) == BASE`. Register index is `addr[3:2]`. `addr[1:0]` is ignored.
- 0x0 TXDATA
  - Write with `cs && wren && wmask[0]` pushes `wdata[7:0]`.
  - Reads return 0.
- 0x4 STATUS
  - Read value: `{15'b0, overflow, 6'b0, full, empty, 3'b0, count[4:0]}`; `count` is zero-extended for any DEPTH.
  - Write with `wmask[2]` and `wdata[16]=1` clears `overflow`.
- 0x8 TICKS
  - 32-bit counter: 0 in the first cycle after reset, then +1 every cycle, wrapping at 2^32.
  - Read-only; writes are ignored.
- 0xC SCRATCH
  - 32-bit read/write.
  - Each byte lane is written only when its `wmask` bit is set.
- FIFO
  - Circular buffer with read and write pointers of `$clog2(DEPTH)` bits.
  - Count is `$clog2(DEPTH)+1` bits.
  - `empty = count==0`, `full = count==DEPTH`.
- Pop occurs when `sig_tx_valid && tock_tx_ready`. The read pointer advances with wrap.
- Push occurs when the TXDATA write condition holds and `!full || pop`. A push while full with no pop in the same cycle is dropped and sets `overflow`.
- Simultaneous push and pop leaves the count unchanged; both pointers advance.
- Read path: when `cs && rden`, the selected register value (pre-update, sampled this cycle) is latched into `sig_bus_rdata`. Otherwise `sig_bus_rdata` is 0 next cycle.
  - A read of STATUS or TICKS in the same cycle as a push, pop or write returns the old value.
- `rden` and `wren` in the same cycle are processed independently. The read returns the pre-write value.
- Unselected addresses have no side effects.

## Timing
- Reset (synchronous, 1 cycle minimum) forces:
  - `sig_bus_rdata=0`, `sig_tx_valid=0`, `sig_tx_data=0`, `sig_irq_overflow=0`.
  - Count and pointers 0; TICKS and SCRATCH 0.
  - Reset asserted mid-drain discards FIFO contents.
- Read latency: exactly 1 cycle, matching the core's stage B to stage C.
- Push to `sig_tx_valid`: 1 cycle. The byte pushed in cycle N is visible in cycle N+1.
- `sig_tx_data` is driven from FIFO storage at the read pointer. It is stable while `valid && !ready`.
- Full throughput is 1 byte/cycle when `ready` is held high.
- Overflow sets in the cycle after the dropped write. Clear wins over a simultaneous set.

## Test plan
- Reset, then read STATUS: `rdata` = 32'h00000100 in the cycle after `rden`. Then read TICKS at a known cycle: the value equals the cycle count since reset deassert.
- Push 0x41, 0x42, 0x43 with `ready` held low, then raise `ready`: `tx_data` shows 0x41, 0x42, 0x43 on three consecutive cycles, then `valid` drops.
- With `ready` low, push DEPTH+1 bytes:
  - STATUS reads count=DEPTH, full=1, overflow=1.
  - The drained bytes are exactly the first DEPTH bytes.
  - Writing STATUS with `wdata` 32'h00010000 and `wmask` 4'b0100 clears overflow.
- Full FIFO with push and pop in the same cycle: count stays DEPTH, no overflow, and the new byte appears last. Repeat 3×DEPTH cycles to exercise pointer wrap.
- SCRATCH:
  - Write 32'hDEADBEEF with mask 1111, then 32'h00AA0000 with mask 0100: the read returns 32'hDEAABEEF.
  - A write to address BASE+0x10 leaves all state unchanged.
  - Reads at BASE+0x10 return 0.

Source files
------------

// File: rtl/pinwheel_console.sv
// Debug console peripheral: TX byte FIFO, status, free-running tick counter and scratch
// register behind a 16-byte window, with registered one-cycle read data.
module pinwheel_console #(
   parameter int unsigned DEPTH = 16,
   parameter logic [31:0] BASE  = 32'hF0000000
) (
   input  logic        clock,
   input  logic        tock_reset_in,
   input  logic [31:0] tock_bus_addr,
   input  logic        tock_bus_rden,
   input  logic [31:0] tock_bus_wdata,
   input  logic [3:0]  tock_bus_wmask,
   input  logic        tock_bus_wren,
   output logic [31:0] sig_bus_rdata,
   output logic [7:0]  sig_tx_data,
   output logic        sig_tx_valid,
   input  logic        tock_tx_ready,
   output logic        sig_irq_overflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [PW-1:0] r_rptr;
   logic [PW-1:0] r_wptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic [31:0]   r_ticks;
   logic [31:0]   r_scratch;
   logic [31:0]   r_rdata;

   logic          w_cs;
   logic [1:0]    w_idx;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push_req;
   logic          w_push;
   logic          w_drop;
   logic          w_clr;
   logic [4:0]    w_cnt5;
   logic [31:0]   w_status;
   logic [31:0]   w_rsel;

   always_comb begin
      w_cs       = (tock_bus_addr & ~32'hF) == BASE;
      w_idx      = tock_bus_addr[3:2];
      w_empty    = (r_count == '0);
      w_full     = (r_count == CW'(DEPTH));
      w_pop      = !w_empty && tock_tx_ready;
      w_push_req = w_cs && tock_bus_wren && (w_idx == 2'd0) && tock_bus_wmask[0];
      w_push     = w_push_req && (!w_full || w_pop);
      w_drop     = w_push_req && w_full && !w_pop;
      w_clr      = w_cs && tock_bus_wren && (w_idx == 2'd1) &&
                   tock_bus_wmask[2] && tock_bus_wdata[16];
      w_cnt5     = 5'(r_count);
      w_status   = {15'b0, r_ovf, 6'b0, w_full, w_empty, 3'b0, w_cnt5};
   end

   always_comb begin
      w_rsel = '0;
      case (w_idx)
         2'd0: w_rsel = '0;
         2'd1: w_rsel = w_status;
         2'd2: w_rsel = r_ticks;
         2'd3: w_rsel = r_scratch;
         default: w_rsel = '0;
      endcase
   end

   // Storage is cleared on reset so the head byte reads 0 straight after reset.
   always_ff @(posedge clock) begin
      if (tock_reset_in) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wptr] <= tock_bus_wdata[7:0];
      end
   end

   always_ff @(posedge clock) begin
      if (tock_reset_in) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         if (w_push) r_wptr <= r_wptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_clr)       r_ovf <= 1'b0;
         else if (w_drop) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (tock_reset_in) begin
         r_ticks   <= '0;
         r_scratch <= '0;
         r_rdata   <= '0;
      end else begin
         r_ticks <= r_ticks + 32'd1;
         if (w_cs && tock_bus_wren && (w_idx == 2'd3)) begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (tock_bus_wmask[i]) r_scratch[8*i +: 8] <= tock_bus_wdata[8*i +: 8];
            end
         end
         r_rdata <= (w_cs && tock_bus_rden) ? w_rsel : '0;
      end
   end

   assign sig_bus_rdata    = r_rdata;
   assign sig_tx_data      = r_mem[r_rptr];
   assign sig_tx_valid     = !w_empty;
   assign sig_irq_overflow = r_ovf;

endmodule

// File: tb/tb_pinwheel_console.sv
// Self-checking bench for pinwheel_console: directed steps followed by random traffic,
// compared each cycle against a queue-based model of the console's register rules.
module tb_pinwheel_console;

   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] BASE  = 32'hF0000000;

   logic        clock = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic        rden;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic        wren;
   logic        ready;
   logic [31:0] rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        irq;

   always #5 clock = ~clock;

   pinwheel_console #(.DEPTH(DEPTH), .BASE(BASE)) dut (
      .clock            (clock),
      .tock_reset_in    (rst),
      .tock_bus_addr    (addr),
      .tock_bus_rden    (rden),
      .tock_bus_wdata   (wdata),
      .tock_bus_wmask   (wmask),
      .tock_bus_wren    (wren),
      .sig_bus_rdata    (rdata),
      .sig_tx_data      (tx_data),
      .sig_tx_valid     (tx_valid),
      .tock_tx_ready    (ready),
      .sig_irq_overflow (irq)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]  q[$];
   bit          m_ovf;
   logic [31:0] m_scratch;
   logic [31:0] m_rdata;
   int unsigned m_ticks;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] status_word();
      int unsigned n = q.size();
      return {15'b0, m_ovf, 6'b0, n == DEPTH, n == 0, 3'b0, 5'(n)};
   endfunction

   task automatic check_outputs();
      chk("rdata", rdata, m_rdata);
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) chk("tx_data", {24'b0, tx_data}, {24'b0, q[0]});
      chk("irq_overflow", {31'b0, irq}, {31'b0, m_ovf});
   endtask

   // One bus cycle: drive inputs, advance the model, clock, then compare.
   task automatic step(input logic [31:0] a, input logic r, input logic w,
                       input logic [31:0] d, input logic [3:0] m, input logic rd_y);
      bit          cs;
      logic [1:0]  idx;
      logic [31:0] nr;
      bit          pop, full_before, push_req, clr, set;
      addr = a; rden = r; wren = w; wdata = d; wmask = m; ready = rd_y;
      cs  = (a & 32'hFFFF_FFF0) == BASE;
      idx = a[3:2];
      nr  = 32'd0;
      if (cs && r) begin
         case (idx)
            2'd1: nr = status_word();
            2'd2: nr = m_ticks;
            2'd3: nr = m_scratch;
            default: nr = 32'd0;
         endcase
      end
      pop         = (q.size() != 0) && rd_y;
      full_before = (q.size() == DEPTH);
      push_req    = cs && w && idx == 2'd0 && m[0];
      clr         = cs && w && idx == 2'd1 && m[2] && d[16];
      set         = 1'b0;
      if (pop) void'(q.pop_front());
      if (push_req) begin
         if (!full_before || pop) q.push_back(d[7:0]);
         else set = 1'b1;
      end
      if (clr) m_ovf = 1'b0;
      else if (set) m_ovf = 1'b1;
      if (cs && w && idx == 2'd3)
         for (int i = 0; i < 4; i++) if (m[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
      m_ticks++;
      m_rdata = nr;
      @(posedge clock);
      #1;
      check_outputs();
   endtask

   task automatic idle(input logic rd_y);
      step(BASE + 32'h20, 1'b0, 1'b0, 32'd0, 4'd0, rd_y);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      addr = '0; rden = 0; wren = 0; wdata = '0; wmask = '0; ready = 0;
      @(posedge clock);
      #1;
      rst = 1'b0;
      q.delete();
      m_ovf = 1'b0; m_scratch = '0; m_rdata = '0; m_ticks = 0;
      check_outputs();
      chk("reset_tx_data", {24'b0, tx_data}, 32'd0);
   endtask

   initial begin
      logic [7:0]  abc [3];
      logic [31:0] ra;
      logic [1:0]  sel;
      abc[0] = 8'h41; abc[1] = 8'h42; abc[2] = 8'h43;

      // Reset state and STATUS/TICKS reads.
      do_reset();
      step(BASE + 32'h4, 1, 0, 0, 0, 0);
      chk("status_after_reset", rdata, 32'h00000100);
      for (int i = 0; i < 4; i++) idle(0);
      step(BASE + 32'h8, 1, 0, 0, 0, 0);
      chk("ticks_known_cycle", rdata, 32'd5);

      // Three bytes held, then drained back to back.
      for (int i = 0; i < 3; i++) step(BASE, 0, 1, {24'h0, abc[i]}, 4'b0001, 0);
      for (int i = 0; i < 3; i++) begin
         chk("abc_order", {24'b0, tx_data}, {24'b0, abc[i]});
         idle(1);
      end
      chk("abc_valid_drop", {31'b0, tx_valid}, 32'd0);

      // Overflow: DEPTH+1 pushes with no consumer.
      for (int i = 0; i <= DEPTH; i++) step(BASE + 32'h1, 0, 1, 32'(i + 8'h10), 4'b1111, 0);
      step(BASE + 32'h4, 1, 0, 0, 0, 0);
      chk("status_full_ovf", rdata, 32'h00010210);
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_first_depth", {24'b0, tx_data}, 32'(i + 8'h10));
         idle(1);
      end
      chk("drain_empty", {31'b0, tx_valid}, 32'd0);
      step(BASE + 32'h4, 0, 1, 32'h00010000, 4'b0100, 0);
      chk("ovf_cleared", {31'b0, irq}, 32'd0);

      // Full FIFO with push and pop together, across several pointer wraps.
      for (int i = 0; i < DEPTH; i++) step(BASE, 0, 1, 32'(i), 4'b0001, 0);
      for (int i = 0; i < 3 * DEPTH; i++) step(BASE, 0, 1, 32'(8'h80 + i), 4'b0001, 1);
      step(BASE + 32'h4, 1, 0, 0, 0, 0);
      chk("status_full_no_ovf", rdata, 32'h00000210);
      for (int i = 0; i < DEPTH; i++) idle(1);

      // SCRATCH lanes and out-of-window accesses.
      step(BASE + 32'hC, 0, 1, 32'hDEADBEEF, 4'b1111, 0);
      step(BASE + 32'hC, 0, 1, 32'h00AA0000, 4'b0100, 0);
      step(BASE + 32'hC, 1, 0, 0, 0, 0);
      chk("scratch_lanes", rdata, 32'hDEAABEEF);
      step(BASE + 32'h10, 0, 1, 32'hFFFFFFFF, 4'b1111, 0);
      step(BASE + 32'hC, 1, 0, 0, 0, 0);
      chk("scratch_outside_write", rdata, 32'hDEAABEEF);
      step(BASE + 32'h10, 1, 0, 0, 0, 0);
      chk("read_outside", rdata, 32'd0);
      step(BASE + 32'h4, 1, 0, 0, 0, 0);
      chk("status_outside_write", rdata, 32'h00000100);

      // Random traffic, including resets mid-drain.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            sel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
               0, 1, 2: ra = BASE + {28'h0, sel, 2'b00};
               3:       ra = BASE;
               4:       ra = BASE + 32'h10 + {28'h0, sel, 2'b00};
               default: ra = $urandom;
            endcase
            ra[1:0] = 2'($urandom_range(0, 3));
            step(ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 4'($urandom), $urandom_range(0, 2) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
